sync_fifo_ctrl: RTL
===================

Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised FIFO with selectable read mode: standard (registered output) or first-word-fall-through (FWFT).
- Adds parameter-set almost_full/almost_empty thresholds, sticky overflow/underflow error flags, and a synchronous flush.
- Register-array storage, no vendor primitives.
- Used inside a single clock domain, between stream producers/consumers and packetisers.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_BITS, 4, pointer width; FIFO_DEPTH = 2**ADDR_BITS words.
- FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through.
- AF_THRESH, 2**ADDR_BITS-2, almost_full asserts when usedw >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when usedw <= AE_THRESH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 freezes all state.
- clear  in  1  synchronous flush.
- wr_req  in  1  write request.
- rd_req  in  1  read request (pop).
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  usedw == FIFO_DEPTH.
- almost_full  out  1  usedw >= AF_THRESH.
- empty  out  1  usedw == 0.
- almost_empty  out  1  usedw <= AE_THRESH.
- usedw  out  ADDR_BITS+1  stored word count, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst low, asynchronous) forces these values:
  - wr_ptr = rd_ptr = usedw = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, data_out = 0.
  - Memory contents are don't-care.
- Pointers are ADDR_BITS wide and wrap naturally from FIFO_DEPTH-1 to 0.
- Flags are registered and consistent with usedw in the same cycle.
- Accepted write: wr_req & en & !clear & (!full | rd_accept).
  - mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted read (rd_accept): rd_req & en & !clear & !empty.
  - rd_ptr increments.
- usedw: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with wr_req and rd_req together: both accepted, usedw stays FIFO_DEPTH, no overflow.
- Empty with wr_req and rd_req together: write accepted, read rejected, underflow set, usedw becomes 1.
- overflow sets on wr_req & en & !clear while full and no read is accepted.
- underflow sets on rd_req & en & !clear while empty.
- overflow and underflow stay set until clear or reset.
- FWFT=0 (standard mode):
  - On an accepted read, data_out <= mem[rd_ptr], valid the cycle after rd_req.
  - Otherwise data_out holds its value.
  - A rejected read leaves data_out unchanged.
- FWFT=1 (fall-through mode):
  - data_out = mem[rd_ptr] whenever !empty, and 0 when empty.
  - rd_req acknowledges (pops) the displayed word.
  - A write into an empty FIFO makes empty deassert, with the word on data_out, on the next cycle.
- clear = 1 with en = 1:
  - Next cycle: pointers, usedw, overflow, underflow and data_out go to 0; flags return to reset values.
  - clear takes priority over wr_req/rd_req in the same cycle; nothing is written or read.
- en = 0: all requests and clear are ignored; outputs and pointers hold; no error flags set.
- Reset asserted mid-operation returns everything to reset values immediately; the first operation after release behaves as on an empty FIFO.

Test Plan:
- Bench configuration: DATA_WIDTH=32, ADDR_BITS=4, AF_THRESH=14, AE_THRESH=2.
- Reset, then write 0x1555 and 0xAAA, then FWFT=0 read twice:
  - data_out = 0x1555, then 0xAAA, each one cycle after rd_req.
  - usedw 2 -> 1 -> 0; empty reasserts.
- Write 16 words 0..15:
  - almost_full rises when usedw = 14; full rises at 16.
  - A 17th write sets overflow; usedw stays 16.
  - A read then returns 0 (the oldest word; the rejected write was not stored).
- Full, then wr_req+rd_req for 4 cycles:
  - usedw stays 16, no overflow.
  - Reads return 0..3; writes wrap wr_ptr past 15.
- Empty, rd_req alone, then wr_req+rd_req together:
  - underflow set; data_out unchanged.
  - After the simultaneous pair usedw = 1.
- FWFT=1, write 0xDEADBEEF to an empty FIFO:
  - Next cycle empty = 0 and data_out = 0xDEADBEEF without rd_req.
  - rd_req pops it; empty = 1 and data_out = 0.
- With usedw = 5 and overflow set:
  - clear with wr_req high: next cycle usedw = 0, empty = 1, overflow = 0, and the write is dropped.
  - en = 0 with wr_req: usedw holds 0.
  - rst low mid-burst: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// Stream-side bundle of the synchronous FIFO controller: request/flush
// controls and write data from the producer/consumer, read data plus
// occupancy and error flags from the FIFO.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 4
);
    logic                  en;
    logic                  clear;
    logic                  wr_req;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_BITS:0]    usedw;
    logic                  overflow;
    logic                  underflow;

    // Client side: drives requests and data, observes the FIFO.
    modport master (
        output en, clear, wr_req, rd_req, data_in,
        input  data_out, full, almost_full, empty, almost_empty,
               usedw, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  en, clear, wr_req, rd_req, data_in,
        output data_out, full, almost_full, empty, almost_empty,
               usedw, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock register-array FIFO with standard or first-word-fall-through
// read mode, threshold flags, sticky overflow/underflow and synchronous flush.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 2**ADDR_BITS - 2,
    parameter int AE_THRESH  = 2
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int FIFO_DEPTH = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(FIFO_DEPTH);
    localparam logic [ADDR_BITS:0] AF_CNT    = (ADDR_BITS+1)'(AF_THRESH);
    localparam logic [ADDR_BITS:0] AE_CNT    = (ADDR_BITS+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]    usedw_q, usedw_nxt;
    logic                  full_q, af_q, empty_q, ae_q;
    logic                  ovf_q, unf_q;
    logic                  flush, op_ok, rd_ok, wr_ok;

    // Request qualification and next occupancy.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        flush     = bus.en & bus.clear;
        op_ok     = bus.en & ~bus.clear;
        rd_ok     = op_ok & bus.rd_req & ~empty_q;
        // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
        wr_ok     = op_ok & bus.wr_req & (~full_q | rd_ok);
        usedw_nxt = usedw_q;
        if (flush)
            usedw_nxt = '0;
        else if (wr_ok && !rd_ok)
            usedw_nxt = usedw_q + 1'b1;
        else if (rd_ok && !wr_ok)
            usedw_nxt = usedw_q - 1'b1;
    end

    // Pointers, count, registered flags and sticky errors; en = 0 freezes all of it.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.en) begin
            // Flags derive from the next count so they line up with usedw.
            usedw_q <= usedw_nxt;
            full_q  <= (usedw_nxt == DEPTH_CNT);
            af_q    <= (usedw_nxt >= AF_CNT);
            empty_q <= (usedw_nxt == '0);
            ae_q    <= (usedw_nxt <= AE_CNT);
            if (bus.clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
                if (bus.wr_req && full_q && !rd_ok) ovf_q <= 1'b1;
                if (bus.rd_req && empty_q)          unf_q <= 1'b1;
            end
        end
    end

    // Storage write port.
    // NOTE: the array is deliberately not reset; its contents are never visible before being written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; empty forces zero so flush/reset read back 0.
            assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            // Registered read port: loads on an accepted pop, otherwise holds.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    dout_q <= '0;
                else if (flush)
                    dout_q <= '0;
                else if (rd_ok)
                    dout_q <= mem[rd_ptr];
            end

            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.usedw        = usedw_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
